nn_mac_sequencer: RTL
=====================

# nn_mac_sequencer

Sequencer that time-multiplexes one shared multiply-accumulate datapath across the two fully connected layers of the PLL neural network: 36 inputs → 20 hidden neurons (7-bit, through the activation function) → 10 outputs (8-bit). On `start` it walks every neuron of layer 1 and then layer 2. For each term it issues input/hidden-buffer and weight-ROM addresses, drives the MAC clear/enable strobes, and writes each finished neuron into the hidden or output buffer. It replaces the fully parallel combinational network with a serial schedule; the controller itself contains no arithmetic on data.

## Interface
Parameters:
- `N_IN`, 36, layer-1 fan-in (input count)
- `N_HID`, 20, hidden neuron count (layer-2 fan-in)
- `N_OUT`, 10, output neuron count
- `AW_W`, 10, weight-ROM address width, ≥ clog2(N_IN·N_HID + N_HID·N_OUT)

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  level-sampled in IDLE; begins one inference
- `abort`  in  1  synchronous; returns to IDLE on the next edge with no `done`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when all outputs are written
- `in_addr`  out  6  input-buffer read address (term k, layer 1)
- `hid_rd_addr`  out  5  hidden-buffer read address (term k, layer 2)
- `w_addr`  out  AW_W  weight-ROM read address
- `mac_src`  out  1  0 = input operand, 1 = hidden operand
- `mac_en`  out  1  MAC consumes the operand/weight presented this cycle
- `mac_clr`  out  1  with `mac_en`: load the product instead of accumulating
- `hid_wr_en`  out  1  write activation(acc) into the hidden buffer
- `hid_wr_addr`  out  5  hidden neuron index
- `out_wr_en`  out  1  write acc into the output buffer
- `out_wr_addr`  out  4  output neuron index

## Operation
- States: IDLE, L1_ISSUE, L1_WB, L2_ISSUE, L2_WB, DONE.
- IDLE → L1_ISSUE when `start`=1. n=0, k=0, `w_addr`=0.
- L1_ISSUE: presents `in_addr`=k, `w_addr`=n·N_IN+k, `mac_src`=0. k increments each cycle. After k=N_IN−1 → L1_WB.
- L1_WB (2 cycles):
  - Cycle 1 is the drain cycle, with `mac_en` for the last term.
  - Cycle 2 asserts `hid_wr_en`, `hid_wr_addr`=n.
  - Then n+1 → L1_ISSUE, or after n=N_HID−1 → L2_ISSUE with n=0.
- L2_ISSUE/L2_WB: same pattern with `hid_rd_addr`=k, `mac_src`=1, `w_addr`=N_IN·N_HID + n·N_HID + k, k up to N_HID−1. WB cycle 2 asserts `out_wr_en`, `out_wr_addr`=n. After n=N_OUT−1 → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `w_addr` is held in a running counter: increment per issue; no multiplier. It is not reset between neurons, because the ROM layout is contiguous.
- `mac_en` is the issue flag delayed one cycle, matching the 1-cycle buffer/ROM read latency. `mac_clr` is the k=0 issue flag delayed one cycle.
- `start` while busy: ignored.
- `abort` in any state: next state IDLE. All strobes are low from that edge onward, and no partial write is issued. If `abort` and `start` are both high in IDLE, `abort` wins and the block stays in IDLE.
- Buffer contents are not cleared by the sequencer.

## Timing
- Reset: state IDLE; all outputs 0, including `w_addr`, `in_addr`, and the write addresses.
- Per neuron: N_IN+2 cycles (layer 1), N_HID+2 cycles (layer 2).
- Defaults: 20·38 + 10·22 = 980 cycles in L1/L2 states. `done` is high in the 981st cycle after the edge that samples `start`.
- First issue (`in_addr`=0, `w_addr`=0) is in the cycle after the start edge. The first `mac_en`/`mac_clr` comes one cycle later.
- `hid_wr_en` for neuron n: first cycle of L1 is cycle 1; the write lands in cycle 38(n+1).
- No back-to-back inference: minimum gap of one IDLE cycle between `done` and the next accepted `start`.
- Reset asserted mid-run: immediate return to reset values. Outputs written so far stay in the buffers but are not valid.

## Structure
- Shared package `nn_pkg`: N_IN/N_HID/N_OUT defaults, the layer-2 weight base constant (N_IN·N_HID), the state enum, and the address widths.
- One natural sub-module, `nn_idx_counter`:
  - term counter k with a programmable terminal count (N_IN or N_HID), plus neuron counter n;
  - produces the `last_term`/`last_neuron` flags.
- The sequencer FSM, strobe delay registers, and `w_addr` counter live in the top.

## Test plan
- Reset then one `start`: `busy` rises next cycle. `done` pulses exactly 981 cycles after the start edge. The bench sees 20 `hid_wr_en` (addr 0..19) then 10 `out_wr_en` (addr 0..9).
- Address trace: `w_addr` runs 0..719 with `mac_src`=0, then 720..919 with `mac_src`=1. `in_addr` cycles 0..35 twenty times and `hid_rd_addr` 0..19 ten times. `mac_clr` occurs exactly 30 times.
- Golden model: bench MAC + ROM with known weights gives `out1..out10` equal to the reference arithmetic model for in=all 63 and for a random vector.
- `abort` at cycle 400 (layer 1, neuron 10): next cycle `busy`=0. No `done`, and no further `hid_wr_en`. A following `start` restarts at `w_addr`=0.
- `start` held high for the whole run: exactly one `done`; a second run begins after one IDLE cycle.
- Async `rst` pulse mid-layer-2 (not clock-aligned): all outputs 0 immediately, state IDLE. `start` afterwards produces a full 981-cycle run.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants for the PLL neural-network MAC sequencer: default layer sizes,
// address widths, weight-ROM layout and the sequencer state encoding.
package nn_pkg;

    localparam int N_IN_DEF  = 36;
    localparam int N_HID_DEF = 20;
    localparam int N_OUT_DEF = 10;
    localparam int AW_W_DEF  = 10;

    // Layer-2 weights start right after the layer-1 block in the ROM.
    localparam int W_L2_BASE = N_IN_DEF * N_HID_DEF;

    localparam int IN_AW  = 6;
    localparam int HID_AW = 5;
    localparam int OUT_AW = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_L1_ISSUE = 3'd1;
    localparam logic [2:0] ST_L1_WB    = 3'd2;
    localparam logic [2:0] ST_L2_ISSUE = 3'd3;
    localparam logic [2:0] ST_L2_WB    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/nn_idx_counter.sv
// Term counter k (programmable terminal count, wraps to 0) and neuron counter n,
// with the last-term / last-neuron flags the sequencer branches on.
module nn_idx_counter
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              term_en_i,
    input  logic              neuron_en_i,
    input  logic              neuron_clr_i,
    input  logic [IN_AW-1:0]  term_last_i,
    input  logic [HID_AW-1:0] neuron_last_i,
    output logic [IN_AW-1:0]  k_o,
    output logic [HID_AW-1:0] n_o,
    output logic              last_term_o,
    output logic              last_neuron_o
);

    logic [IN_AW-1:0]  k_q, k_d;
    logic [HID_AW-1:0] n_q, n_d;

    assign last_term_o   = (k_q == term_last_i);
    assign last_neuron_o = (n_q == neuron_last_i);

    always_comb begin
        k_d = k_q;
        n_d = n_q;
        if (clr_i) begin
            k_d = '0;
        end else if (term_en_i) begin
            k_d = last_term_o ? '0 : k_q + IN_AW'(1);
        end
        if (clr_i || neuron_clr_i) begin
            n_d = '0;
        end else if (neuron_en_i) begin
            n_d = n_q + HID_AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q <= '0;
            n_q <= '0;
        end else begin
            k_q <= k_d;
            n_q <= n_d;
        end
    end

    assign k_o = k_q;
    assign n_o = n_q;

endmodule

// File: rtl/nn_mac_sequencer.sv
// Serial schedule for the 36-20-10 network: walks every neuron of both layers
// through one shared MAC, issuing buffer/ROM addresses, MAC strobes and writebacks.
module nn_mac_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int AW_W  = AW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    output logic [HID_AW-1:0] hid_rd_addr,
    output logic [AW_W-1:0]   w_addr,
    output logic              mac_src,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              hid_wr_en,
    output logic [HID_AW-1:0] hid_wr_addr,
    output logic              out_wr_en,
    output logic [OUT_AW-1:0] out_wr_addr
);

    localparam logic [IN_AW-1:0]  L1_K_LAST = IN_AW'(N_IN - 1);
    localparam logic [IN_AW-1:0]  L2_K_LAST = IN_AW'(N_HID - 1);
    localparam logic [HID_AW-1:0] L1_N_LAST = HID_AW'(N_HID - 1);
    localparam logic [HID_AW-1:0] L2_N_LAST = HID_AW'(N_OUT - 1);

    logic [2:0]        state_q, state_d;
    logic              ph_q, ph_d;        // writeback phase: 0 = drain, 1 = write
    logic [AW_W-1:0]   w_q, w_d;
    logic              en_q, clr_q;
    logic              issue, ctr_clr, term_en, n_en, n_clr;
    logic              is_l2, last_term, last_neuron;
    logic [IN_AW-1:0]  k;
    logic [HID_AW-1:0] n;

    assign is_l2 = (state_q == ST_L2_ISSUE) || (state_q == ST_L2_WB);

    nn_idx_counter u_idx (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (ctr_clr),
        .term_en_i     (term_en),
        .neuron_en_i   (n_en),
        .neuron_clr_i  (n_clr),
        .term_last_i   (is_l2 ? L2_K_LAST : L1_K_LAST),
        .neuron_last_i (is_l2 ? L2_N_LAST : L1_N_LAST),
        .k_o           (k),
        .n_o           (n),
        .last_term_o   (last_term),
        .last_neuron_o (last_neuron)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        ph_d    = ph_q;
        w_d     = w_q;
        issue   = 1'b0;
        ctr_clr = 1'b0;
        term_en = 1'b0;
        n_en    = 1'b0;
        n_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ctr_clr = 1'b1;
                w_d     = '0;
                if (start) state_d = ST_L1_ISSUE;
            end
            ST_L1_ISSUE, ST_L2_ISSUE: begin
                issue   = 1'b1;
                term_en = 1'b1;
                w_d     = w_q + AW_W'(1);
                if (last_term) begin
                    state_d = (state_q == ST_L1_ISSUE) ? ST_L1_WB : ST_L2_WB;
                    ph_d    = 1'b0;
                end
            end
            ST_L1_WB, ST_L2_WB: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (!last_neuron) begin
                        state_d = is_l2 ? ST_L2_ISSUE : ST_L1_ISSUE;
                        n_en    = 1'b1;
                    end else begin
                        state_d = is_l2 ? ST_DONE : ST_L2_ISSUE;
                        n_clr   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ctr_clr = 1'b1;
                w_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort dominates everything, including a start seen in IDLE.
        if (abort) begin
            state_d = ST_IDLE;
            ph_d    = 1'b0;
            w_d     = '0;
            issue   = 1'b0;
            ctr_clr = 1'b1;
            term_en = 1'b0;
            n_en    = 1'b0;
            n_clr   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            ph_q    <= 1'b0;
            w_q     <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            w_q     <= w_d;
            en_q    <= issue;
            clr_q   <= issue && (k == '0);
        end
    end

    // MAC strobes lag the issue by the one-cycle buffer/ROM read latency.
    assign mac_en      = en_q;
    assign mac_clr     = clr_q;
    assign mac_src     = is_l2;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign w_addr      = w_q;
    assign in_addr     = (state_q == ST_L1_ISSUE) ? k : '0;
    assign hid_rd_addr = (state_q == ST_L2_ISSUE) ? k[HID_AW-1:0] : '0;
    assign hid_wr_en   = (state_q == ST_L1_WB) && ph_q;
    assign out_wr_en   = (state_q == ST_L2_WB) && ph_q;
    assign hid_wr_addr = hid_wr_en ? n : '0;
    assign out_wr_addr = out_wr_en ? n[OUT_AW-1:0] : '0;

endmodule
